// File: rtl/noise_pkg.sv
// noise_pkg: shared mode type and LFSR constants for the noise channel
package noise_pkg;
    typedef enum logic [1:0] {NOISE_PASS, NOISE_FIXED, NOISE_RAND1, NOISE_RAND2} noise_mode_e;
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/noise_lfsr.sv
// noise_lfsr: 16-bit Galois LFSR with advance, seed load and zero-seed substitution
module noise_lfsr
    import noise_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_adv,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);
    logic [15:0] state_q, state_d;
    // load beats advance; an all-zero seed would lock the register, so SEED stands in
    always_comb state_d = i_load ? (i_seed == '0 ? SEED : i_seed)
                        : i_adv ? ({1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : '0))
                        : state_q;
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state_q <= SEED;
        else          state_q <= state_d;
    assign o_state = state_q;
endmodule

// File: rtl/noise_channel.sv
// noise_channel: registered error-injection channel; statistics counters built only when NOISE_CNT_EN is defined
module noise_channel
    import noise_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter logic [15:0] SEED   = DEFAULT_SEED,
    parameter int          CNT_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_data,
    input  logic [1:0]                i_mode,
    input  logic [$clog2(DATA_W)-1:0] i_pos,
    input  logic [7:0]                i_rate,
    input  logic                      i_seed_load,
    input  logic [15:0]               i_seed,
    input  logic                      i_clr_cnt,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_data,
    output logic [DATA_W-1:0]         o_err_mask,
    output logic [CNT_W-1:0]          o_word_cnt,
    output logic [CNT_W-1:0]          o_err_cnt
);
    localparam int PW  = $clog2(DATA_W);
    localparam int SW  = PW + 1;
    localparam int PRW = 8 + PW + 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    noise_mode_e       mode;
    logic [15:0]       lfsr;
    logic              accept, inj;
    logic [PRW-1:0]    prod1, prod2;
    logic [PW-1:0]     p1, p2;
    logic [SW-1:0]     d, sum;
    logic [DATA_W-1:0] mask;
    logic [1:0]        nflip;
    logic              valid_q;
    logic [DATA_W-1:0] data_q, mask_q;

    assign mode    = noise_mode_e'(i_mode);
    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign inj     = (i_rate == 8'hFF) || (lfsr[7:0] < i_rate);

    noise_lfsr #(.SEED(SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_adv   (accept),
        .i_load  (i_seed_load),
        .i_seed  (i_seed),
        .o_state (lfsr)
    );

    // scale LFSR bytes onto bit positions; the second position is offset by 1..DATA_W-1 so it never collides
    always_comb begin
        prod1 = PRW'(lfsr[15:8]) * PRW'(DATA_W);
        prod2 = PRW'(lfsr[7:0]) * PRW'(DATA_W - 1);
        p1    = PW'(prod1 >> 8);
        d     = SW'(prod2 >> 8) + SW'(1);
        sum   = {1'b0, p1} + d;
        p2    = PW'(sum >= SW'(DATA_W) ? sum - SW'(DATA_W) : sum);
        mask  = mode == NOISE_FIXED ? ({1'b0, i_pos} < SW'(DATA_W) ? ONE << i_pos : '0)
              : mode == NOISE_RAND1 && inj ? ONE << p1
              : mode == NOISE_RAND2 && inj ? (ONE << p1) | (ONE << p2)
              : '0;
        nflip = 2'(mask != '0) + 2'(mode == NOISE_RAND2 && inj);
    end

    // single-stage output register; a stalled word holds until downstream takes it
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            if (accept) begin
                data_q <= i_data ^ mask;
                mask_q <= mask;
            end
            if (o_ready) valid_q <= i_valid;
        end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_err_mask = mask_q;

`ifdef NOISE_CNT_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d, wbase, ebase;
    logic [CNT_W:0]   esum;
    // clear applies before the increment so a clear with an accept counts just that word
    always_comb begin
        wbase      = i_clr_cnt ? '0 : word_cnt_q;
        ebase      = i_clr_cnt ? '0 : err_cnt_q;
        esum       = {1'b0, ebase} + (CNT_W + 1)'(nflip);
        word_cnt_d = accept && !(&wbase) ? wbase + CNT_W'(1) : wbase;
        err_cnt_d  = !accept ? ebase : esum[CNT_W] ? '1 : esum[CNT_W-1:0];
    end
    // saturating statistics counters
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    assign o_word_cnt = word_cnt_q;
    assign o_err_cnt  = err_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{i_clr_cnt, nflip};
    assign o_word_cnt = '0;
    assign o_err_cnt  = '0;
`endif
endmodule

// File: tb/tb_noise_channel.sv
// tb_noise_channel: randomized self-checking bench for noise_channel against an arithmetic reference model
module tb_noise_channel;
    localparam int DW   = 8;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          i_clk = 0, i_rst_n = 0, i_valid = 0, i_seed_load = 0, i_clr_cnt = 0, i_ready = 1;
    logic          o_ready, o_valid;
    logic [DW-1:0] i_data = '0, o_data, o_err_mask;
    logic [1:0]    i_mode = '0;
    logic [2:0]    i_pos = '0;
    logic [7:0]    i_rate = '0;
    logic [15:0]   i_seed = '0;
    logic [CW-1:0] o_word_cnt, o_err_cnt;

    int checks = 0, errors = 0;
    int m_lfsr = 'hACE1, m_word = 0, m_err = 0;
    logic [DW-1:0] seqs [4][64];

    noise_channel #(.DATA_W(DW), .SEED(16'hACE1), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_mode(i_mode), .i_pos(i_pos), .i_rate(i_rate),
        .i_seed_load(i_seed_load), .i_seed(i_seed), .i_clr_cnt(i_clr_cnt),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_err_mask(o_err_mask),
        .o_word_cnt(o_word_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic int lfsr_next(int l);
        return (l >> 1) ^ ((l & 1) != 0 ? 'hB400 : 0);
    endfunction

    function automatic logic [DW-1:0] model_mask(int l, int mode, int pos, int rate);
        int lo = l % 256;
        int hi = l / 256;
        bit inj = (rate == 255) || (lo < rate);
        int p1 = hi * DW / 256;
        int p2 = (p1 + 1 + lo * (DW - 1) / 256) % DW;
        int m = 0;
        if (mode == 1 && pos < DW) m = 1 << pos;
        if (mode == 2 && inj) m = 1 << p1;
        if (mode == 3 && inj) m = (1 << p1) | (1 << p2);
        return m[DW-1:0];
    endfunction

    function automatic int ecnt(int v);
`ifdef NOISE_CNT_EN
        return v;
`else
        return v & 0;
`endif
    endfunction

    task automatic do_word(input logic [DW-1:0] data, input logic [1:0] mode, input logic [2:0] pos,
                           input logic [7:0] rate, output logic [DW-1:0] em);
        em = model_mask(m_lfsr, mode, pos, rate);
        i_valid = 1; i_data = data; i_mode = mode; i_pos = pos; i_rate = rate;
        @(posedge i_clk);
        if (i_clr_cnt) begin m_word = 0; m_err = 0; end
        m_word = m_word + 1 > CMAX ? CMAX : m_word + 1;
        m_err  = m_err + $countones(em) > CMAX ? CMAX : m_err + $countones(em);
        m_lfsr = i_seed_load ? (i_seed == 0 ? 'hACE1 : int'(i_seed)) : lfsr_next(m_lfsr);
        #1;
        i_clr_cnt = 0; i_seed_load = 0;
    endtask

    task automatic idle(input int n);
        i_valid = 0;
        repeat (n) begin
            @(posedge i_clk);
            if (i_clr_cnt) begin m_word = 0; m_err = 0; end
            if (i_seed_load) m_lfsr = i_seed == 0 ? 'hACE1 : int'(i_seed);
            #1;
            i_clr_cnt = 0; i_seed_load = 0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge i_clk);
        #1;
        checks += 5;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", o_valid); end
        if (o_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", o_data); end
        if (o_err_mask !== '0) begin errors++; $display("FAIL reset_mask got %0h want 0", o_err_mask); end
        if (o_word_cnt !== '0) begin errors++; $display("FAIL reset_wcnt got %0d want 0", o_word_cnt); end
        if (o_err_cnt !== '0) begin errors++; $display("FAIL reset_ecnt got %0d want 0", o_err_cnt); end
        i_rst_n = 1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", o_ready); end
    endtask

    task automatic test_fixed;
        logic [DW-1:0] em, d;
        logic [2:0] p;
        do_word(8'h00, 2'd1, 3'd3, 8'd0, em);
        checks += 5;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid got %0h want 1", o_valid); end
        if (o_data !== 8'h08) begin errors++; $display("FAIL fixed_data got %0h want 08", o_data); end
        if (o_err_mask !== 8'h08) begin errors++; $display("FAIL fixed_mask got %0h want 08", o_err_mask); end
        if (o_word_cnt !== CW'(ecnt(1))) begin errors++; $display("FAIL fixed_wcnt got %0d want %0d", o_word_cnt, ecnt(1)); end
        if (o_err_cnt !== CW'(ecnt(1))) begin errors++; $display("FAIL fixed_ecnt got %0d want %0d", o_err_cnt, ecnt(1)); end
        for (int i = 0; i < 24; i++) begin
            d = DW'($urandom); p = 3'($urandom);
            do_word(d, 2'd1, p, 8'($urandom), em);
            checks += 2;
            if (o_data !== (d ^ (DW'(1) << p))) begin errors++; $display("FAIL fixed_rand_data got %0h want %0h", o_data, d ^ (DW'(1) << p)); end
            if (o_err_mask !== em) begin errors++; $display("FAIL fixed_rand_mask got %0h want %0h", o_err_mask, em); end
        end
    endtask

    task automatic test_pass;
        logic [DW-1:0] em, d;
        int e0 = m_err;
        for (int i = 0; i < 1000; i++) begin
            d = DW'($urandom);
            do_word(d, 2'd0, 3'($urandom), 8'($urandom), em);
            checks += 2;
            if (o_data !== d) begin errors++; $display("FAIL pass_data got %0h want %0h", o_data, d); end
            if (o_word_cnt !== CW'(ecnt(m_word))) begin errors++; $display("FAIL pass_wcnt got %0d want %0d", o_word_cnt, ecnt(m_word)); end
        end
        checks++;
        if (o_err_cnt !== CW'(ecnt(e0))) begin errors++; $display("FAIL pass_ecnt got %0d want %0d", o_err_cnt, ecnt(e0)); end
    endtask

    task automatic test_rand;
        logic [DW-1:0] em, d;
        logic [1:0] md;
        for (int i = 0; i < 500; i++) begin
            d = DW'($urandom);
            do_word(d, 2'd2, 3'($urandom), 8'd255, em);
            checks += 3;
            if ($countones(o_err_mask) != 1) begin errors++; $display("FAIL rand1_pop got %0d want 1", $countones(o_err_mask)); end
            if (o_err_mask !== em) begin errors++; $display("FAIL rand1_mask got %0h want %0h", o_err_mask, em); end
            if (o_data !== (d ^ em)) begin errors++; $display("FAIL rand1_data got %0h want %0h", o_data, d ^ em); end
        end
        i_clr_cnt = 1;
        idle(1);
        checks++;
        if (o_err_cnt !== '0) begin errors++; $display("FAIL clr_ecnt got %0d want 0", o_err_cnt); end
        for (int i = 0; i < 500; i++) begin
            d = DW'($urandom);
            do_word(d, 2'd3, 3'($urandom), 8'd255, em);
            checks += 3;
            if ($countones(o_err_mask) != 2) begin errors++; $display("FAIL rand2_pop got %0d want 2", $countones(o_err_mask)); end
            if (o_err_mask !== em) begin errors++; $display("FAIL rand2_mask got %0h want %0h", o_err_mask, em); end
            if (o_data !== (d ^ em)) begin errors++; $display("FAIL rand2_data got %0h want %0h", o_data, d ^ em); end
        end
        checks += 2;
        if (o_err_cnt !== CW'(ecnt(1000))) begin errors++; $display("FAIL rand2_ecnt got %0d want %0d", o_err_cnt, ecnt(1000)); end
        if (o_word_cnt !== CW'(ecnt(500))) begin errors++; $display("FAIL rand2_wcnt got %0d want %0d", o_word_cnt, ecnt(500)); end
        for (int i = 0; i < 50; i++) begin
            do_word(DW'($urandom), 2'd3, 3'($urandom), 8'd0, em);
            checks++;
            if (o_err_mask !== '0) begin errors++; $display("FAIL rate0_mask got %0h want 0", o_err_mask); end
        end
        for (int i = 0; i < 200; i++) begin
            d = DW'($urandom); md = 2'($urandom);
            do_word(d, md, 3'($urandom), 8'($urandom), em);
            checks += 3;
            if (o_err_mask !== em) begin errors++; $display("FAIL mix_mask mode %0d got %0h want %0h", md, o_err_mask, em); end
            if (o_data !== (d ^ em)) begin errors++; $display("FAIL mix_data got %0h want %0h", o_data, d ^ em); end
            if (o_err_cnt !== CW'(ecnt(m_err))) begin errors++; $display("FAIL mix_ecnt got %0d want %0d", o_err_cnt, ecnt(m_err)); end
        end
    endtask

    task automatic test_seed;
        logic [DW-1:0] em, sd [64];
        logic [7:0] sr [64];
        logic [1:0] sm [64];
        logic [15:0] seeds [4];
        seeds = '{16'h1234, 16'h1234, 16'h0000, 16'hACE1};
        for (int i = 0; i < 64; i++) begin
            sd[i] = DW'($urandom); sr[i] = 8'($urandom); sm[i] = 2'($urandom_range(2, 3));
        end
        for (int s = 0; s < 4; s++) begin
            i_seed = seeds[s]; i_seed_load = 1;
            idle(1);
            for (int i = 0; i < 64; i++) begin
                do_word(sd[i], sm[i], 3'd0, sr[i], em);
                seqs[s][i] = o_err_mask;
                checks++;
                if (o_err_mask !== em) begin errors++; $display("FAIL seed_mask seed %0h word %0d got %0h want %0h", seeds[s], i, o_err_mask, em); end
            end
        end
        for (int i = 0; i < 64; i++) begin
            checks += 2;
            if (seqs[1][i] !== seqs[0][i]) begin errors++; $display("FAIL seed_repeat word %0d got %0h want %0h", i, seqs[1][i], seqs[0][i]); end
            if (seqs[2][i] !== seqs[3][i]) begin errors++; $display("FAIL seed_zero word %0d got %0h want %0h", i, seqs[2][i], seqs[3][i]); end
        end
        i_seed = 16'h1234; i_seed_load = 1;
        do_word(sd[0], 2'd3, 3'd0, 8'd255, em);
        checks++;
        if (o_err_mask !== em) begin errors++; $display("FAIL seed_same_cycle got %0h want %0h", o_err_mask, em); end
        do_word(sd[0], sm[0], 3'd0, sr[0], em);
        checks++;
        if (o_err_mask !== seqs[0][0]) begin errors++; $display("FAIL seed_after_accept got %0h want %0h", o_err_mask, seqs[0][0]); end
    endtask

    task automatic test_stall;
        logic [DW-1:0] em, hd, hm, d;
        do_word(DW'($urandom), 2'd3, 3'd0, 8'd255, em);
        hd = o_data; hm = o_err_mask;
        d = DW'($urandom);
        i_ready = 0; i_valid = 1; i_data = d; i_mode = 2'd3; i_rate = 8'd255;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            checks += 4;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0h want 0", o_ready); end
            if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0h want 1", o_valid); end
            if (o_data !== hd) begin errors++; $display("FAIL stall_data got %0h want %0h", o_data, hd); end
            if (o_err_mask !== hm) begin errors++; $display("FAIL stall_mask got %0h want %0h", o_err_mask, hm); end
        end
        i_ready = 1;
        do_word(d, 2'd3, 3'd0, 8'd255, em);
        checks += 2;
        if (o_err_mask !== em) begin errors++; $display("FAIL stall_resume_mask got %0h want %0h", o_err_mask, em); end
        if (o_data !== (d ^ em)) begin errors++; $display("FAIL stall_resume_data got %0h want %0h", o_data, d ^ em); end
    endtask

    task automatic test_clr_accept;
        logic [DW-1:0] em;
        do_word(DW'($urandom), 2'd3, 3'd0, 8'd255, em);
        i_clr_cnt = 1;
        do_word(DW'($urandom), 2'd3, 3'd0, 8'd255, em);
        checks += 2;
        if (o_word_cnt !== CW'(ecnt(1))) begin errors++; $display("FAIL clracc_wcnt got %0d want %0d", o_word_cnt, ecnt(1)); end
        if (o_err_cnt !== CW'(ecnt(2))) begin errors++; $display("FAIL clracc_ecnt got %0d want %0d", o_err_cnt, ecnt(2)); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] em, d;
        do_word(DW'($urandom), 2'd3, 3'd0, 8'd255, em);
        i_ready = 0; i_valid = 0;
        @(posedge i_clk);
        #3;
        i_rst_n = 0;
        #1;
        checks += 4;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0h want 0", o_valid); end
        if (o_word_cnt !== '0) begin errors++; $display("FAIL rstmid_wcnt got %0d want 0", o_word_cnt); end
        if (o_err_cnt !== '0) begin errors++; $display("FAIL rstmid_ecnt got %0d want 0", o_err_cnt); end
        if (o_data !== '0) begin errors++; $display("FAIL rstmid_data got %0h want 0", o_data); end
        @(posedge i_clk);
        #1;
        i_rst_n = 1; i_ready = 1;
        m_lfsr = 'hACE1; m_word = 0; m_err = 0;
        d = DW'($urandom);
        do_word(d, 2'd3, 3'd0, 8'd255, em);
        checks += 3;
        if (o_err_mask !== em) begin errors++; $display("FAIL rstmid_mask got %0h want %0h", o_err_mask, em); end
        if (o_word_cnt !== CW'(ecnt(1))) begin errors++; $display("FAIL rstmid_wcnt2 got %0d want %0d", o_word_cnt, ecnt(1)); end
        if (o_err_cnt !== CW'(ecnt(2))) begin errors++; $display("FAIL rstmid_ecnt2 got %0d want %0d", o_err_cnt, ecnt(2)); end
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_pass;
        test_rand;
        test_seed;
        test_stall;
        test_clr_accept;
        test_reset_mid;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
